// File: rtl/sal_axi_wr_frontend_if.sv
// Bus bundle for the SAL AXI write front end: APB control/status port,
// AXI AW and B channels, scheduler request port and scheduler completion port.
//   slave  : the front end's view (drives awready, b*, req_*, cpl_ready, p*rdata/ready/slverr)
//   master : the surrounding system's view (drives everything else)
`timescale 1ns/1ps
interface sal_axi_wr_frontend_if #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32
);
  // APB
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [11:0]               paddr;
  logic [31:0]               pwdata;
  logic [31:0]               prdata;
  logic                      pready;
  logic                      pslverr;
  // AXI AW
  logic [AXI_ID_WIDTH-1:0]   awid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awvalid;
  logic                      awready;
  // AXI B
  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  // Scheduler request
  logic                      req_valid;
  logic [AXI_ID_WIDTH-1:0]   req_id;
  logic [AXI_ADDR_WIDTH-1:0] req_addr;
  logic [7:0]                req_len;
  logic                      req_ready;
  // Scheduler completion
  logic                      cpl_valid;
  logic [AXI_ID_WIDTH-1:0]   cpl_id;
  logic                      cpl_ready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    output bid, bresp, bvalid,
    input  bready,
    output req_valid, req_id, req_addr, req_len,
    input  req_ready,
    input  cpl_valid, cpl_id,
    output cpl_ready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    input  bid, bresp, bvalid,
    output bready,
    input  req_valid, req_id, req_addr, req_len,
    output req_ready,
    output cpl_valid, cpl_id,
    input  cpl_ready
  );
endinterface

// File: rtl/sal_axi_wr_frontend.sv
// SAL DDR controller AXI write-address front end.
// Accepts AW requests, flags illegal bursts (non-INCR or size != bus width),
// forwards legal ones to the write scheduler and returns B responses, either
// from scheduler completions (OKAY) or generated for illegal requests (SLVERR).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sal_axi_wr_frontend_if.slave (APB regs, AW, B, req, cpl)
// APB map: 0x00 CTRL[0]=ENABLE, 0x04 STATUS {B occ[11:8], AW occ[3:0]},
//          0x08 ERR_CNT (write clears), 0x0C AW_CNT.
`timescale 1ns/1ps

// Synchronous FIFO; push while full is accepted only when a pop happens in
// the same cycle.
module sal_axi_wr_frontend_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module sal_axi_wr_frontend #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input logic                   clk,
  input logic                   rst,
  sal_axi_wr_frontend_if.slave  bus
);
  localparam int unsigned AWW = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 1;
  localparam int unsigned BW  = AXI_ID_WIDTH + 2;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH+1);
  localparam logic [2:0]  SIZE_LEGAL = 3'($clog2(AXI_DATA_WIDTH/8));

  logic        ctrl_en_q;
  logic [15:0] err_cnt_q;
  logic [31:0] aw_cnt_q;

  logic apb_acc, apb_wr, apb_rd, addr_ok;
  logic aw_hs, aw_illegal;

  logic [AWW-1:0]            aw_din, aw_head;
  logic                      aw_full, aw_empty, aw_pop;
  logic [CW-1:0]             aw_count;
  logic [AXI_ID_WIDTH-1:0]   head_id;
  logic [AXI_ADDR_WIDTH-1:0] head_addr;
  logic [7:0]                head_len;
  logic                      head_err;

  logic [BW-1:0] b_din, b_head;
  logic          b_full, b_empty, b_push, b_pop;
  logic [CW-1:0] b_count;
  logic          cpl_hs, err_pop;

  logic unused_pwdata;
  assign unused_pwdata = ^bus.pwdata[31:1];

  // APB decode
  assign apb_acc = bus.psel & bus.penable;
  assign apb_wr  = apb_acc & bus.pwrite;
  assign apb_rd  = apb_acc & ~bus.pwrite;
  assign addr_ok = bus.paddr inside {12'h000, 12'h004, 12'h008, 12'h00C};

  // AW intake
  assign bus.awready = ctrl_en_q & ~aw_full;
  assign aw_hs       = bus.awvalid & bus.awready;
  assign aw_illegal  = (bus.awburst != 2'b01) | (bus.awsize != SIZE_LEGAL);
  assign aw_din      = {bus.awid, bus.awaddr, bus.awlen, aw_illegal};

  sal_axi_wr_frontend_fifo #(
    .WIDTH (AWW),
    .DEPTH (FIFO_DEPTH)
  ) u_aw_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (aw_hs),
    .data_i  (aw_din),
    .pop_i   (aw_pop),
    .data_o  (aw_head),
    .full_o  (aw_full),
    .empty_o (aw_empty),
    .count_o (aw_count)
  );

  assign {head_id, head_addr, head_len, head_err} = aw_head;

  assign bus.req_valid = ~aw_empty & ~head_err;
  assign bus.req_id    = head_id;
  assign bus.req_addr  = head_addr;
  assign bus.req_len   = head_len;

  // A completion owns the single B push slot; an error head waits for a
  // cycle without cpl_valid.
  assign cpl_hs        = bus.cpl_valid & ~b_full;
  assign bus.cpl_ready = ~b_full;
  assign err_pop       = ~aw_empty & head_err & ~b_full & ~bus.cpl_valid;
  assign aw_pop        = (bus.req_valid & bus.req_ready) | err_pop;
  assign b_push        = cpl_hs | err_pop;
  assign b_din         = cpl_hs ? {bus.cpl_id, 2'b00} : {head_id, 2'b10};

  sal_axi_wr_frontend_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_b_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (b_push),
    .data_i  (b_din),
    .pop_i   (b_pop),
    .data_o  (b_head),
    .full_o  (b_full),
    .empty_o (b_empty),
    .count_o (b_count)
  );

  assign bus.bvalid = ~b_empty;
  assign b_pop      = bus.bvalid & bus.bready;
  assign {bus.bid, bus.bresp} = b_head;

  // Control/status registers; a clearing write to ERR_CNT wins over a
  // same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en_q <= 1'b0;
      err_cnt_q <= '0;
      aw_cnt_q  <= '0;
    end else begin
      if (apb_wr && bus.paddr == 12'h000) ctrl_en_q <= bus.pwdata[0];
      if (apb_wr && bus.paddr == 12'h008)
        err_cnt_q <= '0;
      else if (aw_hs && aw_illegal && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 16'd1;
      if (aw_hs) aw_cnt_q <= aw_cnt_q + 32'd1;
    end
  end

  assign bus.pready  = 1'b1;
  assign bus.pslverr = apb_acc & ~addr_ok;

  always_comb begin
    bus.prdata = '0;
    if (apb_rd) begin
      case (bus.paddr)
        12'h000: bus.prdata = {31'd0, ctrl_en_q};
        12'h004: bus.prdata = {20'd0, 4'(b_count), 4'd0, 4'(aw_count)};
        12'h008: bus.prdata = {16'd0, err_cnt_q};
        12'h00C: bus.prdata = aw_cnt_q;
        default: bus.prdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_sal_axi_wr_frontend.sv
// Self-checking bench for sal_axi_wr_frontend: directed scenarios followed by
// randomized traffic, every cycle compared with a queue-based reference model.
`timescale 1ns/1ps
module tb_sal_axi_wr_frontend;
  localparam int unsigned IDW   = 4;
  localparam int unsigned ADW   = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sal_axi_wr_frontend_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(ADW)) bus ();

  sal_axi_wr_frontend #(
    .AXI_ID_WIDTH   (IDW),
    .AXI_ADDR_WIDTH (ADW),
    .AXI_DATA_WIDTH (64),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [ADW-1:0] addr;
    logic [7:0]     len;
    bit             err;
  } aw_t;
  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } b_t;

  aw_t         awq[$];
  b_t          bq[$];
  bit          m_en;
  int unsigned m_err_cnt;
  logic [31:0] m_aw_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          chk_on   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against the model, advance the model with the
  // inputs currently applied, then move to the next falling edge.
  task automatic step();
    bit          acc, exp_awready, exp_reqv, exp_cplr, exp_bvalid, exp_slverr;
    bit          aw_push, req_pop, err_pop, cpl_push, b_pop, illegal;
    logic [31:0] exp_prdata;
    #1;
    acc         = bus.psel && bus.penable;
    exp_awready = m_en && awq.size() < DEPTH;
    exp_reqv    = awq.size() > 0 && !awq[0].err;
    exp_cplr    = bq.size() < DEPTH;
    exp_bvalid  = bq.size() > 0;
    exp_slverr  = acc && !(bus.paddr inside {12'h000, 12'h004, 12'h008, 12'h00C});
    exp_prdata  = 32'd0;
    if (acc && !bus.pwrite) begin
      case (bus.paddr)
        12'h000: exp_prdata = {31'd0, m_en};
        12'h004: exp_prdata = (bq.size() << 8) | awq.size();
        12'h008: exp_prdata = m_err_cnt;
        12'h00C: exp_prdata = m_aw_cnt;
        default: exp_prdata = 32'd0;
      endcase
    end
    if (chk_on) begin
      check_eq("awready", bus.awready, exp_awready);
      check_eq("req_valid", bus.req_valid, exp_reqv);
      if (exp_reqv) begin
        check_eq("req_id", bus.req_id, awq[0].id);
        check_eq("req_addr", bus.req_addr, awq[0].addr);
        check_eq("req_len", bus.req_len, awq[0].len);
      end
      check_eq("cpl_ready", bus.cpl_ready, exp_cplr);
      check_eq("bvalid", bus.bvalid, exp_bvalid);
      if (exp_bvalid) begin
        check_eq("bid", bus.bid, bq[0].id);
        check_eq("bresp", bus.bresp, bq[0].resp);
      end
      check_eq("pready", bus.pready, 1);
      check_eq("pslverr", bus.pslverr, exp_slverr);
      check_eq("prdata", bus.prdata, exp_prdata);
    end
    if (rst) begin
      awq.delete();
      bq.delete();
      m_en      = 1'b0;
      m_err_cnt = 0;
      m_aw_cnt  = '0;
    end else begin
      aw_push  = bus.awvalid && exp_awready;
      req_pop  = exp_reqv && bus.req_ready;
      err_pop  = awq.size() > 0 && awq[0].err && bq.size() < DEPTH && !bus.cpl_valid;
      cpl_push = bus.cpl_valid && exp_cplr;
      b_pop    = exp_bvalid && bus.bready;
      illegal  = (bus.awburst != 2'b01) || (bus.awsize != 3'd3);
      if (b_pop) void'(bq.pop_front());
      if (cpl_push) bq.push_back('{id: bus.cpl_id, resp: 2'b00});
      else if (err_pop) bq.push_back('{id: awq[0].id, resp: 2'b10});
      if (req_pop || err_pop) void'(awq.pop_front());
      if (aw_push) begin
        awq.push_back('{id: bus.awid, addr: bus.awaddr, len: bus.awlen, err: illegal});
        m_aw_cnt = m_aw_cnt + 32'd1;
      end
      if (acc && bus.pwrite && bus.paddr == 12'h000) m_en = bus.pwdata[0];
      if (acc && bus.pwrite && bus.paddr == 12'h008) m_err_cnt = 0;
      else if (aw_push && illegal && m_err_cnt < 16'hFFFF) m_err_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = addr; bus.pwdata = data;
    step();
    bus.penable = 1'b1;
    step();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = addr;
    step();
    bus.penable = 1'b1;
    #1;
    data = bus.prdata;
    err  = bus.pslverr;
    step();
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic aw_send(input logic [IDW-1:0] id, input logic [ADW-1:0] addr,
                         input logic [2:0] size, input logic [1:0] burst);
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'd0;
    bus.awsize = size; bus.awburst = burst;
    step();
    bus.awvalid = 1'b0;
  endtask

  logic [31:0] rd;
  logic        rerr;
  logic [11:0] rand_addrs [6];

  initial begin
    rand_addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h7FC};
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
    bus.awsize = 3'd3; bus.awburst = 2'b01;
    bus.bready = 0; bus.req_ready = 0; bus.cpl_valid = 0; bus.cpl_id = 0;

    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_on = 1'b1;
    step();
    step();

    // CTRL reset value, enable, awready follows
    apb_read(12'h000, rd, rerr);
    check_eq("ctrl_reset", rd, 0);
    apb_write(12'h000, 32'd1);
    #1 check_eq("awready_after_en", bus.awready, 1);
    apb_read(12'h000, rd, rerr);
    check_eq("ctrl_readback", rd, 1);

    // single legal write, completion, AW_CNT
    aw_send(4'd0, 32'h0, 3'd3, 2'b01);
    #1 check_eq("req_valid_lat", bus.req_valid, 1);
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    bus.cpl_valid = 1'b1; bus.cpl_id = 4'd0;
    step();
    bus.cpl_valid = 1'b0;
    #1 check_eq("bvalid_lat", bus.bvalid, 1);
    check_eq("bresp_okay", bus.bresp, 0);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    apb_read(12'h00C, rd, rerr);
    check_eq("aw_cnt_one", rd, 1);

    // two queued requests
    aw_send(4'd1, 32'h0, 3'd3, 2'b01);
    aw_send(4'd2, 32'h4, 3'd3, 2'b01);
    apb_read(12'h004, rd, rerr);
    check_eq("status_two", rd, 32'h2);
    bus.req_ready = 1'b1;
    step();
    step();
    bus.req_ready = 1'b0;

    // illegal burst produces SLVERR two cycles after the handshake
    aw_send(4'd3, 32'h40, 3'd3, 2'b10);
    #1 check_eq("illegal_no_req", bus.req_valid, 0);
    check_eq("illegal_bvalid_n1", bus.bvalid, 0);
    step();
    check_eq("illegal_bvalid_n2", bus.bvalid, 1);
    check_eq("illegal_bresp", bus.bresp, 2);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    apb_read(12'h008, rd, rerr);
    check_eq("err_cnt_one", rd, 1);
    apb_write(12'h008, 32'hDEAD);
    apb_read(12'h008, rd, rerr);
    check_eq("err_cnt_clear", rd, 0);

    // fill AW FIFO
    for (int i = 0; i < 5; i++) aw_send(IDW'(i), ADW'(i * 8), 3'd3, 2'b01);
    #1 check_eq("awready_full", bus.awready, 0);
    bus.req_ready = 1'b1;
    repeat (4) step();
    bus.req_ready = 1'b0;

    // fill B FIFO
    for (int i = 0; i < 4; i++) begin
      bus.cpl_valid = 1'b1; bus.cpl_id = IDW'(i + 8);
      step();
    end
    bus.cpl_valid = 1'b0;
    #1 check_eq("cpl_ready_full", bus.cpl_ready, 0);
    apb_read(12'h004, rd, rerr);
    check_eq("status_b_full", rd, 32'h400);
    bus.bready = 1'b1;
    repeat (4) step();
    bus.bready = 1'b0;

    // completion beats a waiting error head
    aw_send(4'd5, 32'h80, 3'd3, 2'b00);
    bus.cpl_valid = 1'b1; bus.cpl_id = 4'd6;
    step();
    bus.cpl_valid = 1'b0;
    step();
    bus.bready = 1'b1;
    #1 check_eq("order_first_id", bus.bid, 6);
    check_eq("order_first_resp", bus.bresp, 0);
    step();
    check_eq("order_second_id", bus.bid, 5);
    check_eq("order_second_resp", bus.bresp, 2);
    step();
    bus.bready = 1'b0;

    apb_read(12'h020, rd, rerr);
    check_eq("bad_addr_slverr", rerr, 1);
    check_eq("bad_addr_prdata", rd, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.awvalid   = ($urandom_range(0, 1) == 1);
      bus.awid      = IDW'($urandom);
      bus.awaddr    = $urandom;
      bus.awlen     = 8'($urandom);
      bus.awsize    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd3;
      bus.awburst   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b01;
      bus.req_ready = ($urandom_range(0, 9) < 6);
      bus.cpl_valid = ($urandom_range(0, 9) < 3);
      bus.cpl_id    = IDW'($urandom);
      bus.bready    = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) == 0) begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite  = ($urandom_range(0, 3) == 0);
        bus.paddr   = rand_addrs[$urandom_range(0, 5)];
        bus.pwdata  = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
      end else begin
        bus.psel    = ($urandom_range(0, 7) == 0);
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
      end
      step();
    end
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    bus.awvalid = 0; bus.cpl_valid = 0; bus.req_ready = 0; bus.bready = 0;
    apb_write(12'h000, 32'd1);

    // reset with traffic in flight
    aw_send(4'd1, 32'h100, 3'd3, 2'b01);
    aw_send(4'd2, 32'h104, 3'd3, 2'b01);
    bus.cpl_valid = 1'b1; bus.cpl_id = 4'd3;
    step();
    bus.cpl_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 check_eq("rst_awready", bus.awready, 0);
    check_eq("rst_req_valid", bus.req_valid, 0);
    check_eq("rst_bvalid", bus.bvalid, 0);
    check_eq("rst_cpl_ready", bus.cpl_ready, 1);
    apb_read(12'h004, rd, rerr);
    check_eq("rst_status", rd, 0);
    apb_read(12'h00C, rd, rerr);
    check_eq("rst_aw_cnt", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
